oob_device_controller: RTL and testbench

Device-side SATA out-of-band (OOB) responder for the PHY layer. It is the counterpart of the host OOB controller and lets the core act as a drive or loopback target.
- It detects the host COMRESET and answers with COMINIT.
- It waits for the host COMWAKE and answers with COMWAKE.
- It transmits ALIGN primitives until the host locks and returns ALIGNs, then sends SYNC and asserts `linkup`.
- It sits between the transceiver OOB/8b10b wrapper and the device link layer.

---
 rtl/oob_device_controller.sv | 240 ++++++++++++++++++++++++
 tb/tb_oob_device_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oob_device_controller.sv
// rtl/oob_device_controller.sv - device-side SATA OOB responder (COMINIT/COMWAKE/ALIGN/SYNC)
module oob_device_controller #(
    parameter logic [31:0] SEND_TIMEOUT       = 32'h000000A2,
    parameter logic [31:0] WAKE_TIMEOUT       = 32'h000203AD,
    parameter logic [31:0] ALIGN_TIMEOUT      = 32'h000203AD,
    parameter logic [1:0]  ALIGN_DETECT_COUNT = 2'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        platform_ready,
    input  logic        comm_reset_detect,
    input  logic        comm_wake_detect,
    input  logic        tx_oob_complete,
    input  logic [31:0] rx_din,
    input  logic [3:0]  rx_is_k,
    input  logic        rx_is_elec_idle,
    input  logic        phy_error,
    output logic        linkup,
    output logic        platform_error,
    output logic        tx_comm_init,
    output logic        tx_comm_wake,
    output logic [31:0] tx_dout,
    output logic        tx_is_k,
    output logic        tx_set_elec_idle,
    output logic [3:0]  lax_state
);

    localparam logic [3:0] ST_IDLE          = 4'd0;
    localparam logic [3:0] ST_WAIT_NO_RESET = 4'd1;
    localparam logic [3:0] ST_SEND_INIT     = 4'd2;
    localparam logic [3:0] ST_WAIT_WAKE     = 4'd3;
    localparam logic [3:0] ST_WAIT_NO_WAKE  = 4'd4;
    localparam logic [3:0] ST_SEND_WAKE     = 4'd5;
    localparam logic [3:0] ST_SEND_ALIGN    = 4'd6;
    localparam logic [3:0] ST_SEND_SYNC     = 4'd7;
    localparam logic [3:0] ST_READY         = 4'd8;

    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;

    // Count value at which the next qualifying ALIGN completes the lock run
    localparam logic [1:0] ALIGN_LAST = ALIGN_DETECT_COUNT - 2'd1;

    logic [3:0]  state;
    logic [3:0]  next_state;
    logic [31:0] timer;
    logic        timer_load;
    logic [31:0] timer_load_val;
    logic [1:0]  align_cnt;
    logic [1:0]  align_cnt_next;
    logic        timeout;
    logic        align_det;
    logic        sync_det;
    logic        force_reset;

    logic        linkup_d;
    logic        platform_error_d;
    logic        tx_comm_init_d;
    logic        tx_comm_wake_d;
    logic [31:0] tx_dout_d;
    logic        tx_is_k_d;
    logic        tx_set_elec_idle_d;

    // Electrical-idle status is informational only; the handshake does not use it
    logic        unused_rx_elec_idle;
    assign unused_rx_elec_idle = rx_is_elec_idle;

    assign timeout     = (timer == 32'd0);
    assign align_det   = (rx_is_k != 4'd0) && (rx_din == PRIM_ALIGN) && !phy_error;
    assign sync_det    = (rx_is_k != 4'd0) && (rx_din == PRIM_SYNC);
    // A host COMRESET restarts the handshake from anywhere past the reset wait
    assign force_reset = comm_reset_detect && (state != ST_IDLE) && (state != ST_WAIT_NO_RESET);
    assign lax_state   = state;

    // State, timer, ALIGN run counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            timer            <= 32'd0;
            align_cnt        <= 2'd0;
            linkup           <= 1'b0;
            platform_error   <= 1'b0;
            tx_comm_init     <= 1'b0;
            tx_comm_wake     <= 1'b0;
            tx_dout          <= 32'd0;
            tx_is_k          <= 1'b0;
            tx_set_elec_idle <= 1'b1;
        end else begin
            state     <= next_state;
            align_cnt <= align_cnt_next;
            if (timer_load) begin
                timer <= timer_load_val;
            end else if (timer != 32'd0) begin
                timer <= timer - 32'd1;
            end
            linkup           <= linkup_d;
            platform_error   <= platform_error_d;
            tx_comm_init     <= tx_comm_init_d;
            tx_comm_wake     <= tx_comm_wake_d;
            tx_dout          <= tx_dout_d;
            tx_is_k          <= tx_is_k_d;
            tx_set_elec_idle <= tx_set_elec_idle_d;
        end
    end

    // Next-state selection with timer loads and ALIGN run tracking
    always_comb begin
        next_state     = state;
        timer_load     = 1'b0;
        timer_load_val = 32'd0;
        align_cnt_next = align_cnt;
        if (force_reset) begin
            next_state = ST_WAIT_NO_RESET;
        end else if (!platform_ready && (state != ST_IDLE)) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (platform_ready && comm_reset_detect) begin
                        next_state = ST_WAIT_NO_RESET;
                    end
                end
                ST_WAIT_NO_RESET: begin
                    if (!comm_reset_detect) begin
                        next_state     = ST_SEND_INIT;
                        timer_load     = 1'b1;
                        timer_load_val = SEND_TIMEOUT;
                    end
                end
                ST_SEND_INIT: begin
                    if (timeout || tx_oob_complete) begin
                        next_state     = ST_WAIT_WAKE;
                        timer_load     = 1'b1;
                        timer_load_val = WAKE_TIMEOUT;
                    end
                end
                ST_WAIT_WAKE: begin
                    if (comm_wake_detect) begin
                        next_state = ST_WAIT_NO_WAKE;
                    end else if (timeout) begin
                        next_state     = ST_SEND_INIT;
                        timer_load     = 1'b1;
                        timer_load_val = SEND_TIMEOUT;
                    end
                end
                ST_WAIT_NO_WAKE: begin
                    if (!comm_wake_detect) begin
                        next_state     = ST_SEND_WAKE;
                        timer_load     = 1'b1;
                        timer_load_val = SEND_TIMEOUT;
                    end
                end
                ST_SEND_WAKE: begin
                    if (timeout || tx_oob_complete) begin
                        next_state     = ST_SEND_ALIGN;
                        timer_load     = 1'b1;
                        timer_load_val = ALIGN_TIMEOUT;
                        align_cnt_next = 2'd0;
                    end
                end
                ST_SEND_ALIGN: begin
                    align_cnt_next = align_det ? (align_cnt + 2'd1) : 2'd0;
                    if (align_det && (align_cnt == ALIGN_LAST)) begin
                        next_state     = ST_SEND_SYNC;
                        timer_load     = 1'b1;
                        timer_load_val = ALIGN_TIMEOUT;
                    end else if (timeout) begin
                        next_state = ST_IDLE;
                    end
                end
                ST_SEND_SYNC: begin
                    if (sync_det) begin
                        next_state = ST_READY;
                    end else if (timeout) begin
                        next_state = ST_IDLE;
                    end
                end
                ST_READY: begin
                    next_state = ST_READY;
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Output values registered on the next edge, derived from the current state
    always_comb begin
        linkup_d           = linkup;
        platform_error_d   = platform_error;
        tx_comm_init_d     = 1'b0;
        tx_comm_wake_d     = 1'b0;
        tx_dout_d          = tx_dout;
        tx_is_k_d          = 1'b0;
        tx_set_elec_idle_d = tx_set_elec_idle;
        case (state)
            ST_IDLE: begin
                tx_set_elec_idle_d = 1'b1;
                linkup_d           = 1'b0;
                platform_error_d   = 1'b0;
            end
            ST_SEND_INIT: begin
                // Dropped on the very edge that leaves SEND_INIT
                tx_comm_init_d = (next_state == ST_SEND_INIT);
            end
            ST_SEND_WAKE: begin
                tx_comm_wake_d = (next_state == ST_SEND_WAKE);
            end
            ST_SEND_ALIGN: begin
                tx_set_elec_idle_d = 1'b0;
                tx_dout_d          = PRIM_ALIGN;
                tx_is_k_d          = 1'b1;
            end
            ST_SEND_SYNC: begin
                tx_dout_d = PRIM_SYNC;
                tx_is_k_d = 1'b1;
            end
            ST_READY: begin
                linkup_d  = 1'b1;
                tx_dout_d = PRIM_SYNC;
                tx_is_k_d = 1'b1;
                if (phy_error) begin
                    platform_error_d = 1'b1;
                end
            end
            default: begin
                tx_is_k_d = 1'b0;
            end
        endcase
        if (force_reset) begin
            linkup_d           = 1'b0;
            tx_set_elec_idle_d = 1'b1;
            tx_comm_init_d     = 1'b0;
            tx_comm_wake_d     = 1'b0;
            tx_is_k_d          = 1'b0;
        end
    end

endmodule

// File: tb/tb_oob_device_controller.sv
// tb/tb_oob_device_controller.sv - randomized and directed bench for oob_device_controller
module tb_oob_device_controller;

    localparam int ST = 24;
    localparam int WT = 16;
    localparam int AT = 40;
    localparam int ADC = 3;
    localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC  = 32'hB5B5957C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        platform_ready = 1'b0;
    logic        comm_reset_detect = 1'b0;
    logic        comm_wake_detect = 1'b0;
    logic        tx_oob_complete = 1'b0;
    logic [31:0] rx_din = 32'd0;
    logic [3:0]  rx_is_k = 4'd0;
    logic        rx_is_elec_idle = 1'b0;
    logic        phy_error = 1'b0;
    logic        linkup;
    logic        platform_error;
    logic        tx_comm_init;
    logic        tx_comm_wake;
    logic [31:0] tx_dout;
    logic        tx_is_k;
    logic        tx_set_elec_idle;
    logic [3:0]  lax_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: state number, cycles spent in it, length of current ALIGN run
    int          m_state = 0;
    int          m_cis   = 0;
    int          m_run   = 0;
    logic        m_linkup = 1'b0, m_perr = 1'b0, m_init = 1'b0, m_wake = 1'b0;
    logic        m_k = 1'b0, m_eidle = 1'b1;
    logic [31:0] m_dout = 32'd0;

    oob_device_controller #(
        .SEND_TIMEOUT(ST), .WAKE_TIMEOUT(WT), .ALIGN_TIMEOUT(AT), .ALIGN_DETECT_COUNT(2'd3)
    ) dut (
        .clk(clk), .rst(rst), .platform_ready(platform_ready),
        .comm_reset_detect(comm_reset_detect), .comm_wake_detect(comm_wake_detect),
        .tx_oob_complete(tx_oob_complete), .rx_din(rx_din), .rx_is_k(rx_is_k),
        .rx_is_elec_idle(rx_is_elec_idle), .phy_error(phy_error), .linkup(linkup),
        .platform_error(platform_error), .tx_comm_init(tx_comm_init),
        .tx_comm_wake(tx_comm_wake), .tx_dout(tx_dout), .tx_is_k(tx_is_k),
        .tx_set_elec_idle(tx_set_elec_idle), .lax_state(lax_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int limit_of(input int s);
        case (s)
            2, 5:    return ST;
            3:       return WT;
            6, 7:    return AT;
            default: return 0;
        endcase
    endfunction

    // One clock of the handshake rules, applied to the inputs held across the edge
    task automatic model_step();
        bit adet, sdet, tmo, force_rst;
        int nx;
        if (rst) begin
            m_state = 0; m_cis = 0; m_run = 0;
            m_linkup = 0; m_perr = 0; m_init = 0; m_wake = 0;
            m_dout = 0; m_k = 0; m_eidle = 1;
            return;
        end
        adet = (rx_is_k != 0) && (rx_din == ALIGN) && !phy_error;
        sdet = (rx_is_k != 0) && (rx_din == SYNC);
        tmo  = (m_cis >= limit_of(m_state));
        force_rst = comm_reset_detect && (m_state > 1);
        nx = m_state;
        if (force_rst) nx = 1;
        else if (!platform_ready && m_state != 0) nx = 0;
        else begin
            case (m_state)
                0: if (platform_ready && comm_reset_detect) nx = 1;
                1: if (!comm_reset_detect) nx = 2;
                2: if (tmo || tx_oob_complete) nx = 3;
                3: if (comm_wake_detect) nx = 4; else if (tmo) nx = 2;
                4: if (!comm_wake_detect) nx = 5;
                5: if (tmo || tx_oob_complete) nx = 6;
                6: if (adet && (m_run + 1 == ADC)) nx = 7; else if (tmo) nx = 0;
                7: if (sdet) nx = 8; else if (tmo) nx = 0;
                default: nx = m_state;
            endcase
        end
        m_init = !force_rst && m_state == 2 && nx == 2;
        m_wake = !force_rst && m_state == 5 && nx == 5;
        m_k    = !force_rst && (m_state >= 6);
        if (m_state == 0) begin m_eidle = 1; m_linkup = 0; m_perr = 0; end
        if (m_state == 6) begin m_eidle = 0; m_dout = ALIGN; end
        if (m_state >= 7) m_dout = SYNC;
        if (m_state == 8) begin m_linkup = 1; if (phy_error) m_perr = 1; end
        if (force_rst) begin m_linkup = 0; m_eidle = 1; end
        if (m_state == 6) m_run = adet ? m_run + 1 : 0;
        if (nx == 6 && m_state == 5) m_run = 0;
        m_cis = (nx != m_state) ? 0 : m_cis + 1;
        m_state = nx;
    endtask

    task automatic compare_all();
        check("state", {28'd0, lax_state}, m_state[31:0]);
        check("linkup", {31'd0, linkup}, {31'd0, m_linkup});
        check("platform_error", {31'd0, platform_error}, {31'd0, m_perr});
        check("tx_comm_init", {31'd0, tx_comm_init}, {31'd0, m_init});
        check("tx_comm_wake", {31'd0, tx_comm_wake}, {31'd0, m_wake});
        check("tx_dout", tx_dout, m_dout);
        check("tx_is_k", {31'd0, tx_is_k}, {31'd0, m_k});
        check("tx_set_elec_idle", {31'd0, tx_set_elec_idle}, {31'd0, m_eidle});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        comm_reset_detect = 0; comm_wake_detect = 0; tx_oob_complete = 0;
        rx_din = 0; rx_is_k = 0; phy_error = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1; tick(); rst = 0;
    endtask

    // Quick path from reset into SEND_ALIGN using tx_oob_complete pulses
    task automatic to_send_align();
        do_reset();
        platform_ready = 1;
        comm_reset_detect = 1; tick();
        comm_reset_detect = 0; tick();
        tx_oob_complete = 1; tick();
        tx_oob_complete = 0; comm_wake_detect = 1; tick();
        comm_wake_detect = 0; tick();
        tx_oob_complete = 1; tick();
        tx_oob_complete = 0;
    endtask

    task automatic send_rx(input logic [31:0] d, input logic [3:0] k);
        rx_din = d; rx_is_k = k; tick();
    endtask

    // Host-like random stimulus biased by where the reference believes the link is
    task automatic random_inputs();
        clear_inputs();
        case (m_state)
            0: begin platform_ready = ($urandom % 8) != 0; comm_reset_detect = $urandom % 2; end
            1: comm_reset_detect = ($urandom % 4) == 0;
            2: tx_oob_complete = ($urandom % 6) == 0;
            3: comm_wake_detect = ($urandom % 5) == 0;
            4: comm_wake_detect = ($urandom % 3) == 0;
            5: tx_oob_complete = ($urandom % 4) == 0;
            6: begin
                if (($urandom % 5) != 0) begin rx_din = ALIGN; rx_is_k = 4'($urandom_range(1, 15)); end
                else begin rx_din = $urandom; rx_is_k = 4'($urandom % 2); end
                phy_error = ($urandom % 20) == 0;
            end
            7: begin
                rx_din = ($urandom % 2) ? SYNC : ALIGN;
                rx_is_k = ($urandom % 6) ? 4'h1 : 4'h0;
            end
            default: phy_error = ($urandom % 10) == 0;
        endcase
        if (m_state >= 2) begin
            if (($urandom % 60) == 0) comm_reset_detect = 1;
            if (($urandom % 60) == 0) platform_ready = 0; else platform_ready = 1;
        end
        rx_is_elec_idle = $urandom % 2;
    endtask

    initial begin
        logic [3:0] seq[$];
        logic [3:0] exp_seq[8];
        int cnt;

        // Reset
        rst = 1; tick(); tick();
        check("rst_eidle", {31'd0, tx_set_elec_idle}, 32'd1);
        check("rst_linkup", {31'd0, linkup}, 32'd0);
        check("rst_dout", tx_dout, 32'd0);
        check("rst_state", {28'd0, lax_state}, 32'd0);
        rst = 0;

        // Full handshake
        platform_ready = 1;
        seq.delete();
        comm_reset_detect = 1;
        for (int i = 0; i < 10; i++) begin tick(); if (seq.size() == 0 || seq[$] != lax_state) seq.push_back(lax_state); end
        comm_reset_detect = 0;
        for (int i = 0; i < 21; i++) begin tick(); if (seq[$] != lax_state) seq.push_back(lax_state); end
        tx_oob_complete = 1; tick(); tx_oob_complete = 0; if (seq[$] != lax_state) seq.push_back(lax_state);
        comm_wake_detect = 1;
        for (int i = 0; i < 10; i++) begin tick(); if (seq[$] != lax_state) seq.push_back(lax_state); end
        comm_wake_detect = 0; tick(); if (seq[$] != lax_state) seq.push_back(lax_state);
        tx_oob_complete = 1; tick(); tx_oob_complete = 0; if (seq[$] != lax_state) seq.push_back(lax_state);
        for (int i = 0; i < 3; i++) begin
            send_rx(ALIGN, 4'h1);
            if (i == 0) check("hs_dout_align", tx_dout, ALIGN);
            if (seq[$] != lax_state) seq.push_back(lax_state);
        end
        send_rx(SYNC, 4'h1); if (seq[$] != lax_state) seq.push_back(lax_state);
        tick();
        check("hs_linkup", {31'd0, linkup}, 32'd1);
        check("hs_dout_sync", tx_dout, SYNC);
        check("hs_seq_len", seq.size(), 32'd8);
        for (int i = 0; i < 8; i++) exp_seq[i] = 4'(i + 1);
        for (int i = 0; i < 8 && i < seq.size(); i++) check("hs_seq", {28'd0, seq[i]}, {28'd0, exp_seq[i]});

        // Error handling in READY
        phy_error = 1; tick(); phy_error = 0; tick(); tick();
        check("err_sticky", {31'd0, platform_error}, 32'd1);
        comm_reset_detect = 1; tick();
        check("err_creset_state", {28'd0, lax_state}, 32'd1);
        check("err_creset_linkup", {31'd0, linkup}, 32'd0);
        check("err_creset_eidle", {31'd0, tx_set_elec_idle}, 32'd1);
        comm_reset_detect = 0;

        // Broken ALIGN run
        to_send_align();
        send_rx(ALIGN, 4'h1); send_rx(ALIGN, 4'h1); send_rx(32'h12345678, 4'h0);
        send_rx(ALIGN, 4'h1); send_rx(ALIGN, 4'h1);
        check("broken_align_stay", {28'd0, lax_state}, 32'd6);
        send_rx(ALIGN, 4'h1);
        check("broken_align_lock", {28'd0, lax_state}, 32'd7);

        // Platform drop in SEND_ALIGN
        to_send_align();
        platform_ready = 0; tick();
        check("pr_drop_idle", {28'd0, lax_state}, 32'd0);
        platform_ready = 1;

        // Wake timeout retries COMINIT
        do_reset();
        comm_reset_detect = 1; tick();
        comm_reset_detect = 0; tick();
        tx_oob_complete = 1; tick(); tx_oob_complete = 0;
        check("wt_in_wait_wake", {28'd0, lax_state}, 32'd3);
        cnt = 0;
        while (cnt < 100) begin
            tick(); cnt++;
            if (lax_state == 4'd2) break;
        end
        check("wt_cycles", cnt, 32'd17);
        tick();
        check("wt_comm_init", {31'd0, tx_comm_init}, 32'd1);

        // Mid-handshake reset
        rst = 1; tick(); rst = 0;
        check("mid_rst_state", {28'd0, lax_state}, 32'd0);
        check("mid_rst_init", {31'd0, tx_comm_init}, 32'd0);

        // Randomized traffic against the reference
        for (int i = 0; i < 4000; i++) begin
            random_inputs();
            if (($urandom % 1500) == 0) rst = 1; else rst = 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
